// File: rtl/preadd_mult_pipe_if.sv
// Operand, control and result bundle of the pre-adder/multiplier stage.
// The upstream driver (master) presents operands and enables; the stage (slave) returns results.
interface preadd_mult_pipe_if #(
    parameter int WIDTH = 18
);
    logic [WIDTH-1:0]      a_in;
    logic [WIDTH-1:0]      b_in;
    logic [WIDTH-1:0]      d_in;
    logic                  in_valid;
    logic                  opmode_4;
    logic                  opmode_6;
    logic                  signed_mode;
    logic                  cea;
    logic                  ceb;
    logic                  cem;

    logic [WIDTH-1:0]      bcout;
    logic                  pre_cout;
    logic [2*WIDTH+11:0]   conc_out;
    logic [2*WIDTH-1:0]    mult_out;
    logic                  out_valid;

    modport master (
        output a_in, b_in, d_in, in_valid, opmode_4, opmode_6, signed_mode, cea, ceb, cem,
        input  bcout, pre_cout, conc_out, mult_out, out_valid
    );

    modport slave (
        input  a_in, b_in, d_in, in_valid, opmode_4, opmode_6, signed_mode, cea, ceb, cem,
        output bcout, pre_cout, conc_out, mult_out, out_valid
    );
endinterface

// File: rtl/preadd_mult_pipe.sv
// DSP pre-adder / multiplier stage: D+/-B pre-adder, optional A1/B1 registers,
// signed/unsigned multiplier and a stallable product pipeline with a travelling valid bit.
module preadd_mult_pipe #(
    parameter int WIDTH      = 18,
    parameter int IREG       = 1,
    parameter int MREG_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    preadd_mult_pipe_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH:0]   pre_full;
    logic [WIDTH-1:0] b_mux;
    logic             c_mux;

    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             pre_c1;
    logic             v1;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;

    // Subtract is d + ~b + 1, so bit WIDTH is the inverted borrow (set when d >= b).
    always_comb begin
        if (bus.opmode_6) begin
            pre_full = {1'b0, bus.d_in} + {1'b0, ~bus.b_in} + (WIDTH+1)'(1);
        end else begin
            pre_full = {1'b0, bus.d_in} + {1'b0, bus.b_in};
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        b_mux = bus.b_in;
        c_mux = 1'b0;
        if (bus.opmode_4) begin
            b_mux = pre_full[WIDTH-1:0];
            c_mux = pre_full[WIDTH];
        end
    end

    if (IREG != 0) begin : g_ireg
        // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                a1     <= '0;
                b1     <= '0;
                pre_c1 <= 1'b0;
                v1     <= 1'b0;
            end else begin
                if (bus.cea) begin
                    a1 <= bus.a_in;
                end
                if (bus.ceb) begin
                    b1     <= b_mux;
                    pre_c1 <= c_mux;
                end
                // A half-captured operand pair is never a valid sample.
                if (bus.cea && bus.ceb) begin
                    v1 <= bus.in_valid;
                end else if (bus.cea || bus.ceb) begin
                    v1 <= 1'b0;
                end
            end
        end
    end else begin : g_no_ireg
        assign a1     = bus.a_in;
        assign b1     = b_mux;
        assign pre_c1 = c_mux;
        assign v1     = bus.in_valid;
    end

    // Extending both operands to the full product width makes one multiplier serve both modes.
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, a1};
        b_ext = {{WIDTH{1'b0}}, b1};
        if (bus.signed_mode) begin
            a_ext = {{WIDTH{a1[WIDTH-1]}}, a1};
            b_ext = {{WIDTH{b1[WIDTH-1]}}, b1};
        end
        prod = a_ext * b_ext;
    end

    if (MREG_DEPTH == 0) begin : g_no_mreg
        assign bus.mult_out  = prod;
        assign bus.out_valid = v1;
    end else begin : g_mreg
        logic [PW-1:0]         m_data [MREG_DEPTH];
        logic [MREG_DEPTH-1:0] m_valid;

        // NOTE: the product stages are a small register file that must read zero after rst, so each entry is cleared explicitly.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < MREG_DEPTH; i++) begin
                    m_data[i] <= '0;
                end
                m_valid <= '0;
            end else if (bus.cem) begin
                m_data[0]  <= prod;
                m_valid[0] <= v1;
                for (int i = 1; i < MREG_DEPTH; i++) begin
                    m_data[i]  <= m_data[i-1];
                    m_valid[i] <= m_valid[i-1];
                end
            end
        end

        assign bus.mult_out  = m_data[MREG_DEPTH-1];
        assign bus.out_valid = m_valid[MREG_DEPTH-1];
    end

    assign bus.bcout    = b1;
    assign bus.pre_cout = pre_c1;
    assign bus.conc_out = {bus.d_in[11:0], a1, b1};

endmodule

// File: doc/preadd_mult_pipe.md
Name: preadd_mult_pipe

Overview:
- Parametrised successor of the DSP pre-adder/multiplier stage.
- Pre-adds or pre-subtracts D and B, registers the A and B operands, then multiplies them with a selectable signed or unsigned mode.
- Carries the product through a configurable-depth M pipeline with a valid flag that moves alongside the data.
- Sits between the input-register stage and the post-adder/accumulator stage, and also drives BCOUT and the 48-bit concatenation bus.

Parameters:
- WIDTH, 18: width of the A, B and D operands; product width is 2*WIDTH.
- IREG, 1: 0 or 1; number of A1/B1 input register stages (0 = combinational pass-through).
- MREG_DEPTH, 1: 0 to 3; number of product pipeline stages after the multiplier.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high; clears every register in the block.
- a_in  in  WIDTH  A operand.
- b_in  in  WIDTH  B operand.
- d_in  in  WIDTH  D operand (pre-adder minuend).
- in_valid  in  1  inputs carry a valid sample this cycle.
- opmode_4  in  1  1 = B1 path takes the pre-adder result; 0 = B1 path takes b_in.
- opmode_6  in  1  0 = pre-add (d+b); 1 = pre-subtract (d-b).
- signed_mode  in  1  1 = two's-complement multiply; 0 = unsigned multiply.
- cea  in  1  clock enable for the A1 register.
- ceb  in  1  clock enable for the B1 register.
- cem  in  1  clock enable for all M pipeline stages.
- bcout  out  WIDTH  B1 stage output.
- pre_cout  out  1  pre-adder carry-out, aligned with bcout.
- conc_out  out  2*WIDTH+12  concatenation {d_in[11:0], a1, b1}.
- mult_out  out  2*WIDTH  product after the M pipeline.
- out_valid  out  1  mult_out holds a valid product.

Behaviour:
- Pre-adder (combinational):
  - sum = d_in + b_in when opmode_6=0; d_in - b_in when opmode_6=1.
  - Result is truncated to WIDTH bits.
  - Carry-out is bit WIDTH of the (WIDTH+1)-bit unsigned result. For subtract it is the inverted borrow: 1 when d_in >= b_in (unsigned).
- B1 input mux: sum and carry-out when opmode_4=1; b_in and carry 0 when opmode_4=0. The B1 register stores this mux output, not raw b_in.
- IREG=1:
  - a1 <= a_in when cea.
  - b1 <= mux output and pre_cout_r <= carry when ceb.
  - A register holds its value while its enable is low.
- IREG=0: a1, b1 and pre_cout follow their inputs combinationally.
- Stage-1 valid (v1):
  - Loads in_valid when cea=1 and ceb=1.
  - Loads 0 when exactly one of cea/ceb is 1 (misaligned capture is invalid).
  - Holds when both are 0.
- Multiplier:
  - Full 2*WIDTH-bit product of a1 and b1.
  - signed_mode=1: both operands are sign-extended.
  - signed_mode=0: both operands are zero-extended.
  - signed_mode is sampled combinationally at multiplier time, so it must be held stable for the sample in flight.
- M pipeline:
  - MREG_DEPTH shift stages for the product plus a parallel valid bit.
  - All stages advance together when cem=1 and hold when cem=0. Holding stalls the sample; it does not drop it.
  - MREG_DEPTH=0: mult_out and out_valid are combinational from stage 1.
- Latency from accepted input to mult_out is IREG + MREG_DEPTH cycles, with all enables high.
- bcout = b1.
- conc_out: d_in is unregistered here and is already aligned upstream.
- Reset:
  - rst=1 at a rising edge clears a1, b1, pre_cout_r, v1, every M stage and every valid bit to 0.
  - Reset overrides all clock enables.
  - Registered outputs read 0 the cycle after reset; out_valid=0.
  - Pass-through paths (IREG=0 / MREG_DEPTH=0) are not affected by rst.
- Reset during operation: every in-flight sample is discarded. The first valid output after reset is the first sample accepted once rst=0.
- Overflow: the pre-adder wraps modulo 2^WIDTH. The multiplier never overflows.

Test Plan:
- Default params: hold rst=1 for 3 cycles with a_in=5, b_in=7, in_valid=1 -> bcout=0, mult_out=0, out_valid=0; first valid output appears 2 cycles after rst drops.
- Pre-add: d=100, b=25, a=3, opmode_4=1, opmode_6=0, signed_mode=0, all ce=1 -> bcout=125 at +1, mult_out=375 and out_valid=1 at +2.
- Pre-subtract signed: d=10, b=25, a=0x3FFFE (-2), opmode_6=1, signed_mode=1 -> bcout=0x3FFF1 (-15), pre_cout=0, mult_out=30.
- Bypass extremes: opmode_4=0, a=b=0x3FFFF:
  - signed_mode=0 -> mult_out=0xFFFF80001.
  - signed_mode=1 -> mult_out=1.
- Enables and stall:
  - cem=0 for 3 cycles mid-stream -> mult_out and out_valid frozen, no sample lost or duplicated after cem=1.
  - cea=1, ceb=0 -> v1=0, and that sample never asserts out_valid.
- Reset mid-flight and pass-through:
  - rst=1 for 1 cycle with 2 samples in flight -> both dropped, out_valid=0 next cycle.
  - IREG=0, MREG_DEPTH=0 -> mult_out equals a_in*b_in in the same cycle.
